ixc_evctl: RTL

IXC_EVCTL -- requirements
Module: ixc_evctl

---
 rtl/ixc_evctl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ixc_evctl.sv
// Purpose  : event-step sequencer for multi-event clock generators (EVAL -> SETTLE -> [BWAIT] -> DONE).
// Latency  : quiet step = stepReq sampled at c0, eventOn at c1, stepDone at c4; +3 cycles per delta pass.
// Backpres : BWAIT holds buffered clocks (bClkHold) until bpWait and all bwOn drop.
//
// Ports:
//   fclk, rst           clock, synchronous active-high reset
//   stepReq             start one step (accepted in IDLE only)
//   active/busy/bwOn    per-generator activity, loop-busy and back-pressure flags
//   bpWait              wired-OR back-pressure wait line
//   eventOn             high exactly while in EVAL
//   bClkHold            high exactly while in BWAIT
//   stepDone            one-cycle pulse in DONE
//   deltaCnt            EVAL passes in current/last step
//   loopErr, tmoErr     sticky error flags, cleared when the next step is accepted
// Build option: define IXC_EVCTL_TIMEOUT_EN to bound BWAIT with a TMO_W-bit timeout counter.
module ixc_evctl #(
   parameter int N_GEN    = 4,
   parameter int MAX_LOOP = 15,
   parameter int TMO_W    = 8
) (
   input  logic             fclk,
   input  logic             rst,
   input  logic             stepReq,
   input  logic [N_GEN-1:0] active,
   input  logic [N_GEN-1:0] busy,
   input  logic [N_GEN-1:0] bwOn,
   input  logic             bpWait,
   output logic             eventOn,
   output logic             bClkHold,
   output logic             stepDone,
   output logic [3:0]       deltaCnt,
   output logic             loopErr,
   output logic             tmoErr
);

   typedef enum logic [2:0] {IDLE, EVAL, SETTLE, BWAIT, DONE} state_t;

   localparam logic [3:0] LOOP_LIM = 4'(MAX_LOOP);

   state_t state;
   logic   settleLate;   // set on the 2nd SETTLE cycle, where generator flags are valid
   logic   anyAct;
   logic   bwPend;

   assign anyAct = (|active) | (|busy);
   assign bwPend = bpWait | (|bwOn);

`ifdef IXC_EVCTL_TIMEOUT_EN
   logic [TMO_W-1:0] tmoCnt;
`else
   // No timeout hardware in this build; TMO_W has no effect here.
   assign tmoErr = (TMO_W > 0) ? 1'b0 : 1'b0;
`endif

   // Outputs are registered alongside the state so each one is a clean flop.
   always_ff @(posedge fclk) begin
      if (rst) begin
         state      <= IDLE;
         settleLate <= 1'b0;
         eventOn    <= 1'b0;
         bClkHold   <= 1'b0;
         stepDone   <= 1'b0;
         deltaCnt   <= 4'd0;
         loopErr    <= 1'b0;
`ifdef IXC_EVCTL_TIMEOUT_EN
         tmoCnt     <= '0;
         tmoErr     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (stepReq) begin
                  state    <= EVAL;
                  eventOn  <= 1'b1;
                  deltaCnt <= 4'd1;
                  loopErr  <= 1'b0;
`ifdef IXC_EVCTL_TIMEOUT_EN
                  tmoErr   <= 1'b0;
`endif
               end
            end
            EVAL: begin
               state      <= SETTLE;
               eventOn    <= 1'b0;
               settleLate <= 1'b0;
            end
            SETTLE: begin
               if (!settleLate) begin
                  settleLate <= 1'b1;
               end else if (anyAct) begin
                  if (deltaCnt < LOOP_LIM) begin
                     state    <= EVAL;
                     eventOn  <= 1'b1;
                     deltaCnt <= (deltaCnt == 4'hF) ? deltaCnt : deltaCnt + 4'd1;
                  end else begin
                     state    <= DONE;
                     stepDone <= 1'b1;
                     loopErr  <= 1'b1;
                  end
               end else if (bwPend) begin
                  state    <= BWAIT;
                  bClkHold <= 1'b1;
`ifdef IXC_EVCTL_TIMEOUT_EN
                  tmoCnt   <= '0;
`endif
               end else begin
                  state    <= DONE;
                  stepDone <= 1'b1;
               end
            end
            BWAIT: begin
               if (!bwPend) begin
                  state    <= DONE;
                  bClkHold <= 1'b0;
                  stepDone <= 1'b1;
               end
`ifdef IXC_EVCTL_TIMEOUT_EN
               // Counter is all-ones on the 2^TMO_W-th hold cycle: give up then.
               else if (&tmoCnt) begin
                  state    <= DONE;
                  bClkHold <= 1'b0;
                  stepDone <= 1'b1;
                  tmoErr   <= 1'b1;
               end else begin
                  tmoCnt <= tmoCnt + TMO_W'(1);
               end
`endif
            end
            DONE: begin
               state    <= IDLE;
               stepDone <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               eventOn  <= 1'b0;
               bClkHold <= 1'b0;
               stepDone <= 1'b0;
            end
         endcase
      end
   end

endmodule
